// File: rtl/io_seq_monitor.sv
// io_seq_monitor: watches synchronised IO pins against a programmed
// sequence of masked values, with per-step timeout and strict mode.
module io_seq_monitor #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TMO_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] io_in,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [AW:0]      seq_len,
  input  logic [TMO_W-1:0] tmo_cycles,
  input  logic             strict,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [AW-1:0]    step_idx
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PASS = 2'd2;
  localparam logic [1:0] FAIL = 2'd3;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_TMO  = 2'b01;
  localparam logic [1:0] CODE_MIS  = 2'b10;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] io_s;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] val_q  [DEPTH];
  logic [WIDTH-1:0] mask_q [DEPTH];
  logic [1:0]       state;
  logic [TMO_W-1:0] timer;
  logic [AW:0]      last_idx;
  logic             hit;
  logic             is_last;
  logic             tmo_hit;
  logic             changed;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1 <= '0;
      io_s  <= '0;
    end else begin
      sync1 <= io_in;
      io_s  <= sync1;
    end
  end

  // Table is frozen while a sequence is running.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i]  <= '0;
        mask_q[i] <= '0;
      end
    end else if (cfg_we && state != RUN) begin
      val_q[cfg_addr]  <= cfg_value;
      mask_q[cfg_addr] <= cfg_mask;
    end
  end

  assign hit = ((io_s ^ val_q[step_idx])
               & mask_q[step_idx]) == '0;
  assign last_idx = seq_len - (AW+1)'(1);
  assign is_last = {1'b0, step_idx} == last_idx;
  assign tmo_hit = (tmo_cycles != '0)
                && (timer == tmo_cycles - TMO_W'(1));
  assign changed = io_s != prev;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      step_idx  <= '0;
      timer     <= '0;
      fail_code <= CODE_NONE;
      prev      <= '0;
    end else if (abort) begin
      state     <= IDLE;
      step_idx  <= '0;
      timer     <= '0;
      fail_code <= CODE_NONE;
    end else begin
      case (state)
        RUN: begin
          prev <= io_s;
          if (hit) begin
            if (is_last) begin
              state <= PASS;
            end else begin
              step_idx <= step_idx + AW'(1);
              timer    <= '0;
            end
          end else if (strict && changed) begin
            state     <= FAIL;
            fail_code <= CODE_MIS;
          end else if (tmo_hit) begin
            state     <= FAIL;
            fail_code <= CODE_TMO;
          end else begin
            timer <= timer + TMO_W'(1);
          end
        end
        default: begin
          if (start) begin
            state     <= (seq_len == '0) ? PASS : RUN;
            step_idx  <= '0;
            timer     <= '0;
            fail_code <= CODE_NONE;
            prev      <= io_s;
          end
        end
      endcase
    end
  end

  assign busy = state == RUN;
  assign pass = state == PASS;
  assign fail = state == FAIL;

endmodule

// File: tb/tb_io_seq_monitor.sv
// tb_io_seq_monitor: directed and random runs of io_seq_monitor
// checked against an outcome-level reference model.
module tb_io_seq_monitor;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [7:0]  io_in = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [7:0]  cfg_value = '0;
  logic [7:0]  cfg_mask = '0;
  logic [2:0]  seq_len = '0;
  logic [15:0] tmo_cycles = '0;
  logic        strict = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_code;
  logic [1:0]  step_idx;

  int errors = 0;
  int checks = 0;

  int e_val [4];
  int e_mask [4];
  int drv [512];
  int seen [512];
  int wr_j = -1;
  int end_j;
  int step1_j;
  int p_end;
  int p_pass;
  int p_code;
  int p_idx;

  io_seq_monitor dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .io_in      (io_in),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_value  (cfg_value),
    .cfg_mask   (cfg_mask),
    .seq_len    (seq_len),
    .tmo_cycles (tmo_cycles),
    .strict     (strict),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .fail_code  (fail_code),
    .step_idx   (step_idx)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_entry(input int a, input int v, input int m);
    cfg_we    = 1'b1;
    cfg_addr  = a[1:0];
    cfg_value = v[7:0];
    cfg_mask  = m[7:0];
    tick();
    cfg_we = 1'b0;
    e_val[a]  = v & 255;
    e_mask[a] = m & 255;
  endtask

  task automatic fill(input int from, input int to, input int v);
    for (int k = from; k <= to; k++) drv[k] = v;
  endtask

  // Outcome model: a step advances on a masked match, a strict run
  // dies on any unmatched change, and a step times out after exactly
  // tmo unmatched evaluations since the step began.
  function automatic void predict(input int n, input int len,
                                  input int tmo, input int st);
    int idx;
    int begin_j;
    idx = 0;
    begin_j = 0;
    p_end = -1;
    p_pass = 0;
    p_code = 0;
    for (int j = 1; j <= n; j++) begin
      int v;
      v = seen[j];
      if (((v ^ e_val[idx]) & e_mask[idx]) == 0) begin
        if (idx == len - 1) begin
          p_end = j;
          p_pass = 1;
          break;
        end
        idx++;
        begin_j = j;
      end else if (st != 0 && v != seen[j-1]) begin
        p_end = j;
        p_code = 2;
        break;
      end else if (tmo != 0 && j - begin_j == tmo) begin
        p_end = j;
        p_code = 1;
        break;
      end
    end
    p_idx = idx;
  endfunction

  task automatic run_seq(input string tag, input int n,
                         input int init, input int len,
                         input int tmo, input int st);
    seq_len = len[2:0];
    tmo_cycles = tmo[15:0];
    strict = st[0];
    io_in = init[7:0];
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    seen[0] = init;
    io_in = drv[0][7:0];
    end_j = -1;
    step1_j = -1;
    for (int j = 1; j <= n; j++) begin
      if (j == wr_j) begin
        cfg_we = 1'b1;
        cfg_addr = 2'd1;
        cfg_value = 8'h77;
        cfg_mask = 8'hFF;
      end
      tick();
      cfg_we = 1'b0;
      seen[j] = (j < 3) ? init : drv[j-3];
      if (!busy && end_j < 0) end_j = j;
      if (busy && step_idx == 2'd1 && step1_j < 0) step1_j = j;
      io_in = drv[j][7:0];
    end
    predict(n, len, tmo, st);
    check($sformatf("%s end_cycle", tag), end_j, p_end);
    check($sformatf("%s busy", tag), busy, p_end < 0);
    check($sformatf("%s pass", tag), pass, p_pass);
    check($sformatf("%s fail", tag), fail,
          p_end >= 0 && p_pass == 0);
    check($sformatf("%s fail_code", tag), fail_code, p_code);
    check($sformatf("%s step_idx", tag), step_idx, p_idx);
  endtask

  task automatic stop_run();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic load_basic();
    cfg_entry(0, 8'h01, 8'hFF);
    cfg_entry(1, 8'h02, 8'hFF);
    cfg_entry(2, 8'h05, 8'hFF);
    fill(0, 9, 8'h01);
    fill(10, 19, 8'h02);
    fill(20, 60, 8'h05);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      e_val[i] = 0;
      e_mask[i] = 0;
    end
    repeat (2) tick();
    check("rst busy", busy, 0);
    check("rst pass", pass, 0);
    check("rst fail", fail, 0);
    check("rst fail_code", fail_code, 0);
    check("rst step_idx", step_idx, 0);
    wb_rst_i = 1'b0;
    tick();

    fill(0, 20, 8'h5A);
    run_seq("reset_entries", 10, 8'hC3, 1, 0, 0);

    load_basic();
    run_seq("basic", 40, 0, 3, 100, 0);
    check("basic pass", pass, 1);
    check("basic step_idx", step_idx, 2);
    check("basic fail_code", fail_code, 0);

    fill(0, 200, 8'h01);
    run_seq("timeout", 150, 0, 3, 100, 0);
    check("timeout fail", fail, 1);
    check("timeout fail_code", fail_code, 1);
    check("timeout gap", end_j - step1_j, 100);

    fill(0, 4, 8'h01);
    fill(5, 40, 8'h03);
    run_seq("strict", 20, 8'h01, 3, 0, 1);
    check("strict fail_code", fail_code, 2);
    check("strict step_idx", step_idx, 1);

    cfg_entry(0, 8'h80, 8'h80);
    fill(0, 40, 8'hFF);
    run_seq("msb_hi", 10, 0, 1, 0, 0);
    check("msb_hi pass", pass, 1);
    fill(0, 40, 8'h7F);
    run_seq("msb_lo", 30, 8'h7F, 1, 0, 0);
    check("msb_lo pass", pass, 0);

    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_start busy", busy, 0);
    check("abort_start pass", pass, 0);
    check("abort_start fail", fail, 0);
    tick();
    check("abort_start idle", busy, 0);

    load_basic();
    wr_j = 5;
    run_seq("run_write", 40, 0, 3, 100, 0);
    wr_j = -1;
    check("run_write pass", pass, 1);
    run_seq("run_write_again", 40, 0, 3, 100, 0);
    check("run_write_again pass", pass, 1);

    seq_len = 3'd3;
    tmo_cycles = 16'd100;
    strict = 1'b0;
    io_in = 8'h00;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    io_in = 8'h01;
    repeat (6) tick();
    check("midrst step_idx", step_idx, 1);
    check("midrst busy", busy, 1);
    wb_rst_i = 1'b1;
    start = 1'b1;
    cfg_we = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    start = 1'b0;
    cfg_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e_val[i] = 0;
      e_mask[i] = 0;
    end
    check("midrst busy0", busy, 0);
    check("midrst pass0", pass, 0);
    check("midrst fail0", fail, 0);
    check("midrst code0", fail_code, 0);
    check("midrst step0", step_idx, 0);
    seq_len = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("len0 pass", pass, 1);
    check("len0 busy", busy, 0);
    check("len0 step_idx", step_idx, 0);

    for (int it = 0; it < 20; it++) begin
      int len;
      int tmo;
      int st;
      int p;
      int k;
      if (busy) stop_run();
      len = $urandom_range(1, 4);
      for (int a = 0; a < 4; a++)
        cfg_entry(a, $urandom_range(0, 255),
                  ($urandom_range(0, 1) != 0) ? 255 :
                  $urandom_range(0, 255));
      tmo = ($urandom_range(0, 1) != 0) ? 0 :
            $urandom_range(3, 20);
      st = ($urandom_range(0, 2) == 0) ? 1 : 0;
      p = 0;
      k = 0;
      while (k <= 100) begin
        int v;
        int hold;
        if ($urandom_range(0, 9) < 7) begin
          v = e_val[p];
          p = (p + 1) % len;
        end else begin
          v = $urandom_range(0, 255);
        end
        hold = $urandom_range(1, 12);
        for (int h = 0; h < hold && k <= 100; h++) begin
          drv[k] = v;
          k++;
        end
      end
      run_seq($sformatf("rnd%0d", it), 100,
              $urandom_range(0, 255), len, tmo, st);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
